// File: rtl/adc_frame_reader_if.sv
// ADC pin bundle plus the tagged sample stream produced by adc_frame_reader.
//   adc_busy_in/adc_dout_in : from the ADC
//   adc_reset_out/adc_convst_out/adc_cs_n_out/adc_sclk_out : to the ADC
//   data_out/chan_out/data_valid_out : sample stream to the oversample filters
// master = reader side, slave = ADC model / downstream side.
interface adc_frame_reader_if #(
    parameter int unsigned W_DATA = 18,
    parameter int unsigned W_CHAN = 3
);
    logic                     adc_busy_in;
    logic                     adc_dout_in;
    logic                     adc_reset_out;
    logic                     adc_convst_out;
    logic                     adc_cs_n_out;
    logic                     adc_sclk_out;
    logic signed [W_DATA-1:0] data_out;
    logic [W_CHAN-1:0]        chan_out;
    logic                     data_valid_out;

    modport master (
        input  adc_busy_in,
        input  adc_dout_in,
        output adc_reset_out,
        output adc_convst_out,
        output adc_cs_n_out,
        output adc_sclk_out,
        output data_out,
        output chan_out,
        output data_valid_out
    );

    modport slave (
        output adc_busy_in,
        output adc_dout_in,
        input  adc_reset_out,
        input  adc_convst_out,
        input  adc_cs_n_out,
        input  adc_sclk_out,
        input  data_out,
        input  chan_out,
        input  data_valid_out
    );
endinterface

// File: rtl/adc_frame_reader.sv
// Serial ADC frame reader (AD760x-style CONVST/BUSY/CS_N/SCLK/DOUT).
// Resets the ADC, runs conversion frames while enable_in is high and emits
// one signed word per channel, tagged with its channel index, as a
// one-cycle strobe.
//   clk_in, reset_n_in : clock, asynchronous active-low reset
//   enable_in          : run continuous frames while high
//   timeout_out        : sticky BUSY timeout flag
//   adc_bus            : ADC pins and the data/chan/valid sample stream
module adc_frame_reader #(
    parameter int unsigned W_DATA     = 18,
    parameter int unsigned N_CHAN     = 8,
    parameter int unsigned W_CHAN     = 3,
    parameter int unsigned SCLK_DIV   = 2,
    parameter int unsigned T_RST      = 5,
    parameter int unsigned T_CONV     = 4,
    parameter int unsigned T_BUSY_MAX = 1000
) (
    input  logic               clk_in,
    input  logic               reset_n_in,
    input  logic               enable_in,
    output logic               timeout_out,
    adc_frame_reader_if.master adc_bus
);

    localparam int unsigned CNT_MAX_A = (T_RST > T_CONV) ? T_RST : T_CONV;
    localparam int unsigned CNT_MAX   = (T_BUSY_MAX > CNT_MAX_A) ? T_BUSY_MAX : CNT_MAX_A;
    localparam int unsigned W_CNT     = $clog2(CNT_MAX + 1);
    localparam int unsigned W_PH      = (SCLK_DIV > 1) ? $clog2(2 * SCLK_DIV) : 1;
    localparam int unsigned W_BIT     = $clog2(W_DATA);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_CONVST,
        ST_WAIT_BUSY,
        ST_READ
    } state_t;

    state_t              state_q, state_d;
    logic [W_CNT-1:0]    cnt_q, cnt_d;
    logic [W_PH-1:0]     ph_q, ph_d;
    logic [W_BIT-1:0]    bit_q, bit_d;
    logic [W_CHAN-1:0]   chan_q, chan_d;
    logic [W_DATA-1:0]   shift_q, shift_d;
    logic                busy_seen_q, busy_seen_d;
    logic                adc_reset_q, adc_reset_d;
    logic                convst_q, convst_d;
    logic                cs_n_q, cs_n_d;
    logic                sclk_q, sclk_d;
    logic signed [W_DATA-1:0] data_q, data_d;
    logic [W_CHAN-1:0]   chan_out_q, chan_out_d;
    logic                valid_q, valid_d;
    logic                timeout_q, timeout_d;
    logic                busy_meta_q, busy_sync_q;

    // BUSY is asynchronous to clk_in: two-flop synchroniser.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            busy_meta_q <= 1'b0;
            busy_sync_q <= 1'b0;
        end else begin
            busy_meta_q <= adc_bus.adc_busy_in;
            busy_sync_q <= busy_meta_q;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            ph_q        <= '0;
            bit_q       <= '0;
            chan_q      <= '0;
            shift_q     <= '0;
            busy_seen_q <= 1'b0;
            adc_reset_q <= 1'b0;
            convst_q    <= 1'b1;
            cs_n_q      <= 1'b1;
            sclk_q      <= 1'b1;
            data_q      <= '0;
            chan_out_q  <= '0;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ph_q        <= ph_d;
            bit_q       <= bit_d;
            chan_q      <= chan_d;
            shift_q     <= shift_d;
            busy_seen_q <= busy_seen_d;
            adc_reset_q <= adc_reset_d;
            convst_q    <= convst_d;
            cs_n_q      <= cs_n_d;
            sclk_q      <= sclk_d;
            data_q      <= data_d;
            chan_out_q  <= chan_out_d;
            valid_q     <= valid_d;
            timeout_q   <= timeout_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ph_d        = ph_q;
        bit_d       = bit_q;
        chan_d      = chan_q;
        shift_d     = shift_q;
        busy_seen_d = busy_seen_q;
        adc_reset_d = adc_reset_q;
        convst_d    = convst_q;
        cs_n_d      = cs_n_q;
        sclk_d      = sclk_q;
        data_d      = data_q;
        chan_out_d  = chan_out_q;
        valid_d     = 1'b0;
        timeout_d   = timeout_q;

        case (state_q)
            ST_INIT: begin
                // Pulse is high while cnt counts 0..T_RST-1, dropped when it hits T_RST.
                if (cnt_q == W_CNT'(T_RST)) begin
                    adc_reset_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = ST_IDLE;
                end else begin
                    adc_reset_d = 1'b1;
                    cnt_d       = cnt_q + W_CNT'(1);
                end
            end

            ST_IDLE: begin
                if (enable_in) begin
                    convst_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = ST_CONVST;
                end
            end

            ST_CONVST: begin
                if (cnt_q == W_CNT'(T_CONV - 1)) begin
                    convst_d    = 1'b1;
                    cnt_d       = '0;
                    busy_seen_d = 1'b0;
                    state_d     = ST_WAIT_BUSY;
                end else begin
                    cnt_d = cnt_q + W_CNT'(1);
                end
            end

            ST_WAIT_BUSY: begin
                if (busy_sync_q) begin
                    busy_seen_d = 1'b1;
                end
                // Conversion done once BUSY has been high and is low again.
                if (busy_seen_q && !busy_sync_q) begin
                    cs_n_d  = 1'b0;
                    sclk_d  = 1'b0;
                    ph_d    = '0;
                    bit_d   = '0;
                    chan_d  = '0;
                    cnt_d   = '0;
                    state_d = ST_READ;
                end else if (cnt_q == W_CNT'(T_BUSY_MAX - 1)) begin
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_INIT;
                end else begin
                    cnt_d = cnt_q + W_CNT'(1);
                end
            end

            ST_READ: begin
                // ph 0..SCLK_DIV-1 is the low half, the rest the high half.
                ph_d = ph_q + W_PH'(1);
                if (ph_q == W_PH'(SCLK_DIV - 1)) begin
                    sclk_d  = 1'b1;
                    shift_d = {shift_q[W_DATA-2:0], adc_bus.adc_dout_in};
                    if (bit_q == W_BIT'(W_DATA - 1)) begin
                        data_d     = {shift_q[W_DATA-2:0], adc_bus.adc_dout_in};
                        chan_out_d = chan_q;
                        valid_d    = 1'b1;
                    end
                end else if (ph_q == W_PH'(2 * SCLK_DIV - 1)) begin
                    ph_d   = '0;
                    sclk_d = 1'b0;
                    if (bit_q == W_BIT'(W_DATA - 1)) begin
                        bit_d = '0;
                        if (chan_q == W_CHAN'(N_CHAN - 1)) begin
                            cs_n_d  = 1'b1;
                            sclk_d  = 1'b1;
                            chan_d  = '0;
                            state_d = ST_IDLE;
                        end else begin
                            chan_d = chan_q + W_CHAN'(1);
                        end
                    end else begin
                        bit_d = bit_q + W_BIT'(1);
                    end
                end
            end

            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    assign adc_bus.adc_reset_out  = adc_reset_q;
    assign adc_bus.adc_convst_out = convst_q;
    assign adc_bus.adc_cs_n_out   = cs_n_q;
    assign adc_bus.adc_sclk_out   = sclk_q;
    assign adc_bus.data_out       = data_q;
    assign adc_bus.chan_out       = chan_out_q;
    assign adc_bus.data_valid_out = valid_q;
    assign timeout_out            = timeout_q;

endmodule

// File: tb/tb_adc_frame_reader.sv
// Bench for adc_frame_reader: behavioural ADC (BUSY pulse, MSB-first DOUT),
// per-frame expected word list, and output monitors.
module tb_adc_frame_reader;

    localparam int unsigned W_DATA     = 18;
    localparam int unsigned N_CHAN     = 8;
    localparam int unsigned W_CHAN     = 3;
    localparam int unsigned SCLK_DIV   = 2;
    localparam int unsigned T_RST      = 5;
    localparam int unsigned T_CONV     = 4;
    localparam int unsigned T_BUSY_MAX = 1000;
    localparam int          WORD_GAP   = W_DATA * 2 * SCLK_DIV;
    localparam int          FRAME_CS   = N_CHAN * WORD_GAP;
    localparam int unsigned W_BSEL     = $clog2(W_DATA);

    logic clk = 1'b0;
    logic reset_n;
    logic enable;
    logic timeout;

    always #5 clk = ~clk;

    adc_frame_reader_if #(.W_DATA(W_DATA), .W_CHAN(W_CHAN)) bus ();

    adc_frame_reader #(
        .W_DATA(W_DATA), .N_CHAN(N_CHAN), .W_CHAN(W_CHAN), .SCLK_DIV(SCLK_DIV),
        .T_RST(T_RST), .T_CONV(T_CONV), .T_BUSY_MAX(T_BUSY_MAX)
    ) dut (
        .clk_in      (clk),
        .reset_n_in  (reset_n),
        .enable_in   (enable),
        .timeout_out (timeout),
        .adc_bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ADC model: words chosen at frame start, shifted out MSB first;
    // the next bit is presented after each SCLK rising edge.
    bit                rand_words = 1'b0;
    logic [W_DATA-1:0] fixed_words [N_CHAN];
    logic [W_DATA-1:0] words [N_CHAN];
    logic [W_DATA-1:0] exp_data [$];
    logic [W_CHAN-1:0] exp_chan [$];
    bit                in_frame = 1'b0;
    int                bitidx = 0;
    logic [W_CHAN-1:0] csel;
    logic [W_BSEL-1:0] bsel;

    always @(bus.adc_cs_n_out or posedge bus.adc_sclk_out) begin
        if (bus.adc_cs_n_out !== 1'b0) begin
            in_frame = 1'b0;
            bitidx = 0;
            bus.adc_dout_in = 1'b0;
        end else if (!in_frame) begin
            in_frame = 1'b1;
            bitidx = 0;
            for (int k = 0; k < N_CHAN; k++) begin
                words[k] = rand_words ? W_DATA'($urandom) : fixed_words[k];
                exp_chan.push_back(W_CHAN'(k));
                exp_data.push_back(words[k]);
            end
            bus.adc_dout_in = words[0][W_DATA-1];
        end else begin
            bitidx++;
            if (bitidx < N_CHAN * W_DATA) begin
                csel = W_CHAN'(bitidx / W_DATA);
                bsel = W_BSEL'(W_DATA - 1 - bitidx % W_DATA);
                bus.adc_dout_in = words[csel][bsel];
            end
        end
    end

    // BUSY model: rises busy_dly cycles after CONVST rises, high busy_len cycles.
    bit busy_en   = 1'b0;
    bit busy_rand = 1'b0;
    int busy_dly  = 2;
    int busy_len  = 10;

    initial begin
        int d;
        int l;
        bus.adc_busy_in = 1'b0;
        forever begin
            @(posedge bus.adc_convst_out);
            if (busy_en) begin
                d = busy_rand ? int'($urandom_range(1, 6)) : busy_dly;
                l = busy_rand ? int'($urandom_range(2, 30)) : busy_len;
                repeat (d) @(posedge clk);
                #1 bus.adc_busy_in = 1'b1;
                repeat (l) @(posedge clk);
                #1 bus.adc_busy_in = 1'b0;
            end
        end
    end

    // Output monitor, sampled on the falling edge.
    logic [W_DATA-1:0] got_data [$];
    logic [W_CHAN-1:0] got_chan [$];
    int got_cyc [$];
    int cs_runs [$];
    int cv_runs [$];
    int rs_runs [$];
    int cv_rise_q [$];
    int cv_gaps [$];
    int cs_run = 0, cv_run = 0, rs_run = 0;
    int n_cs_rise = 0, n_cv_fall = 0;
    int last_cs_rise = 0;
    int to_cyc = -1;
    bit t1_mode = 1'b0;
    int t1_viol = 0;

    always @(negedge clk) begin
        if (bus.data_valid_out === 1'b1) begin
            got_data.push_back(bus.data_out);
            got_chan.push_back(bus.chan_out);
            got_cyc.push_back(cyc);
        end
        if (bus.adc_cs_n_out === 1'b0) cs_run++;
        else if (cs_run > 0) begin
            cs_runs.push_back(cs_run);
            cs_run = 0;
            n_cs_rise++;
            last_cs_rise = cyc;
        end
        if (bus.adc_convst_out === 1'b0) begin
            if (cv_run == 0) begin
                n_cv_fall++;
                cv_gaps.push_back(cyc - last_cs_rise);
            end
            cv_run++;
        end else if (cv_run > 0) begin
            cv_runs.push_back(cv_run);
            cv_run = 0;
            cv_rise_q.push_back(cyc);
        end
        if (bus.adc_reset_out === 1'b1) rs_run++;
        else if (rs_run > 0) begin
            rs_runs.push_back(rs_run);
            rs_run = 0;
        end
        if (timeout === 1'b1 && to_cyc < 0) to_cyc = cyc;
        if (t1_mode && (bus.adc_cs_n_out !== 1'b1 || bus.adc_sclk_out !== 1'b1 ||
                        bus.adc_convst_out !== 1'b1 || bus.data_valid_out !== 1'b0))
            t1_viol++;
    end

    // Bounded wait: 0 strobes, 1 cs_n rises, 2 convst falls, 3 timeout seen.
    task automatic wait_until(input string tag, input int which, input int target, input int limit);
        int k = 0;
        int v;
        forever begin
            case (which)
                0: v = got_chan.size();
                1: v = n_cs_rise;
                2: v = n_cv_fall;
                default: v = (to_cyc >= 0) ? 1 : 0;
            endcase
            if (v >= target || k >= limit) break;
            @(negedge clk);
            k++;
        end
        check({tag, "_wait"}, longint'(v >= target), 1);
    endtask

    // Compare n strobes starting at gbase against the model list from ebase.
    task automatic check_stream(input string tag, input int gbase, input int ebase, input int n);
        for (int i = 0; i < n; i++) begin
            if (gbase + i < got_chan.size() && ebase + i < exp_chan.size()) begin
                check($sformatf("%s_chan%0d", tag, i), longint'(got_chan[gbase+i]), longint'(exp_chan[ebase+i]));
                check($sformatf("%s_data%0d", tag, i), longint'(got_data[gbase+i]), longint'(exp_data[ebase+i]));
                if (i % N_CHAN != 0)
                    check($sformatf("%s_gap%0d", tag, i), longint'(got_cyc[gbase+i] - got_cyc[gbase+i-1]), longint'(WORD_GAP));
            end else begin
                check($sformatf("%s_missing%0d", tag, i), 0, 1);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gb, eb, cb, vb, rb, nc, gp;
        reset_n = 1'b0;
        enable  = 1'b0;
        for (int k = 0; k < N_CHAN; k++) fixed_words[k] = W_DATA'(k);
        fixed_words[0] = 18'h1FFFF;
        fixed_words[1] = 18'h20000;

        // Test 1: reset values, then the ADC reset pulse.
        repeat (3) @(negedge clk);
        check("rst_reset_out", longint'(bus.adc_reset_out), 0);
        check("rst_convst", longint'(bus.adc_convst_out), 1);
        check("rst_cs_n", longint'(bus.adc_cs_n_out), 1);
        check("rst_sclk", longint'(bus.adc_sclk_out), 1);
        check("rst_data", longint'(bus.data_out), 0);
        check("rst_chan", longint'(bus.chan_out), 0);
        check("rst_valid", longint'(bus.data_valid_out), 0);
        check("rst_timeout", longint'(timeout), 0);
        rb = rs_runs.size();
        t1_mode = 1'b1;
        reset_n = 1'b1;
        repeat (15) @(negedge clk);
        t1_mode = 1'b0;
        check("t1_pulse_count", longint'(rs_runs.size() - rb), 1);
        if (rs_runs.size() > rb) check("t1_pulse_len", longint'(rs_runs[rb]), longint'(T_RST));
        check("t1_quiet", longint'(t1_viol), 0);

        // Test 2: single frame with fixed extreme words.
        busy_en = 1'b1; busy_rand = 1'b0; busy_dly = 2; busy_len = 10;
        rand_words = 1'b0;
        gb = got_chan.size(); eb = exp_chan.size(); cb = cs_runs.size(); vb = cv_runs.size();
        nc = n_cs_rise;
        enable = 1'b1;
        wait_until("t2_convst", 2, n_cv_fall + 1, 50);
        enable = 1'b0;
        wait_until("t2_frame", 1, nc + 1, 2000);
        repeat (10) @(negedge clk);
        if (cv_runs.size() > vb) check("t2_convst_len", longint'(cv_runs[vb]), longint'(T_CONV));
        else check("t2_convst_len_missing", 0, 1);
        if (cs_runs.size() > cb) check("t2_cs_len", longint'(cs_runs[cb]), longint'(FRAME_CS));
        else check("t2_cs_len_missing", 0, 1);
        check("t2_strobes", longint'(got_chan.size() - gb), longint'(N_CHAN));
        check_stream("t2", gb, eb, N_CHAN);

        // Test 3: BUSY never rises -> timeout, ADC re-reset, no strobe.
        busy_en = 1'b0;
        gb = got_chan.size(); rb = rs_runs.size();
        enable = 1'b1;
        wait_until("t3_convst", 2, n_cv_fall + 1, 50);
        enable = 1'b0;
        wait_until("t3_timeout", 3, 1, 1200);
        if (cv_rise_q.size() > 0) check("t3_timeout_delay", longint'(to_cyc - cv_rise_q[$]), longint'(T_BUSY_MAX));
        repeat (50) @(negedge clk);
        check("t3_timeout_sticky", longint'(timeout), 1);
        check("t3_no_strobe", longint'(got_chan.size() - gb), 0);
        check("t3_pulse_count", longint'(rs_runs.size() - rb), 1);
        if (rs_runs.size() > rb) check("t3_pulse_len", longint'(rs_runs[rb]), longint'(T_RST));

        // Test 4: enable drops while channel 3 is being read.
        busy_en = 1'b1; busy_rand = 1'b1; rand_words = 1'b1;
        gb = got_chan.size(); eb = exp_chan.size(); nc = n_cs_rise;
        enable = 1'b1;
        wait_until("t4_ch3", 0, gb + 3, 2000);
        repeat (10) @(negedge clk);
        enable = 1'b0;
        wait_until("t4_frame", 1, nc + 1, 1000);
        vb = n_cv_fall;
        repeat (200) @(negedge clk);
        check("t4_strobes", longint'(got_chan.size() - gb), longint'(N_CHAN));
        check_stream("t4", gb, eb, N_CHAN);
        check("t4_no_new_convst", longint'(n_cv_fall - vb), 0);
        check("t4_convst_high", longint'(bus.adc_convst_out), 1);
        check("t4_timeout_still", longint'(timeout), 1);

        // Test 5: async reset during channel 5.
        gb = got_chan.size(); eb = exp_chan.size();
        enable = 1'b1;
        wait_until("t5_ch5", 0, gb + 5, 2000);
        repeat (20) @(negedge clk);
        check("t5_in_frame", longint'(bus.adc_cs_n_out), 0);
        #2 reset_n = 1'b0;
        #1;
        check("t5_cs_n", longint'(bus.adc_cs_n_out), 1);
        check("t5_sclk", longint'(bus.adc_sclk_out), 1);
        check("t5_data", longint'(bus.data_out), 0);
        check("t5_timeout_cleared", longint'(timeout), 0);
        repeat (3) @(negedge clk);
        enable = 1'b0;
        reset_n = 1'b1;
        repeat (100) @(negedge clk);
        check("t5_strobes", longint'(got_chan.size() - gb), 5);
        check_stream("t5", gb, eb, 5);

        // Test 6: three back-to-back frames with random BUSY timing.
        gb = got_chan.size(); eb = exp_chan.size(); nc = n_cs_rise; gp = cv_gaps.size();
        enable = 1'b1;
        wait_until("t6_third_convst", 2, n_cv_fall + 3, 3000);
        enable = 1'b0;
        wait_until("t6_frames", 1, nc + 3, 3000);
        repeat (10) @(negedge clk);
        check("t6_strobes", longint'(got_chan.size() - gb), longint'(3 * N_CHAN));
        check_stream("t6", gb, eb, 3 * N_CHAN);
        check("t6_gap_count", longint'(cv_gaps.size() - gp), 3);
        for (int i = 1; i < 3; i++)
            if (gp + i < cv_gaps.size()) check($sformatf("t6_cs_to_convst%0d", i), longint'(cv_gaps[gp+i]), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
